// File: rtl/apb_regfile_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_regfile_slave                                               |
// | Brief    : APB4 register bank with RO masking, wait states and pslverr.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module apb_regfile_slave #(
  parameter int                   ADDR_W      = 8,
  parameter int                   DATA_W      = 32,
  parameter int                   NUM_REGS    = 16,
  parameter int                   WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q
);

  localparam int              c_NB     = DATA_W / 8;
  localparam int              c_LSB    = $clog2(c_NB);
  localparam int              c_IDX_W  = ADDR_W - c_LSB;
  localparam int              c_NSLOT  = 2 ** c_IDX_W;
  localparam int              c_RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]      c_WAIT   = 4'(WAIT_CYCLES);
  // Mask widened to the full decode space so any index can address it
  localparam logic [c_NSLOT-1:0] c_RO_EXT = c_NSLOT'(RO_MASK);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_pready;
  logic                  r_write;
  logic                  r_err;
  logic                  r_ro;
  logic [c_RIDX_W-1:0]   r_ridx;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_NB-1:0]       r_strb;
  logic [DATA_W-1:0]     r_regs [NUM_REGS];

  logic [c_IDX_W-1:0]    w_idx;
  logic [c_RIDX_W-1:0]   w_ridx;
  logic                  w_oob;
  logic                  w_mis;
  logic                  w_ro;
  logic                  w_err;
  logic [3:0]            w_cnt_nxt;
  logic [DATA_W-1:0]     w_hw [NUM_REGS];
  logic [DATA_W-1:0]     w_rsel;

  assign w_idx     = paddr[ADDR_W-1:c_LSB];
  assign w_ridx    = w_idx[c_RIDX_W-1:0];
  assign w_oob     = int'(w_idx) >= NUM_REGS;
  assign w_ro      = c_RO_EXT[w_idx];
  assign w_err     = w_oob | w_mis | (pwrite & w_ro);
  assign w_cnt_nxt = r_cnt + 4'd1;

  generate
    if (c_LSB > 0) begin : g_mis
      assign w_mis = |paddr[c_LSB-1:0];
    end else begin : g_nomis
      assign w_mis = 1'b0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slices
      assign w_hw[i]                    = hw_status[i*DATA_W +: DATA_W];
      assign regs_q[i*DATA_W +: DATA_W] = r_regs[i];
    end
  endgenerate

  // hw_status feeds prdata directly so it is sampled in the completing cycle
  always_comb begin
    w_rsel = r_ro ? w_hw[r_ridx] : r_regs[r_ridx];
  end

  assign pready  = r_pready;
  assign pslverr = r_pready & r_err;
  assign prdata  = (r_pready && !r_write && !r_err) ? w_rsel : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pready <= 1'b0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_ro     <= 1'b0;
      r_ridx   <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pready <= 1'b0;
          if (psel && !penable) begin
            r_state  <= S_ACCESS;
            r_cnt    <= '0;
            r_ridx   <= w_ridx;
            r_write  <= pwrite;
            r_wdata  <= pwdata;
            r_strb   <= pstrb;
            r_err    <= w_err;
            r_ro     <= w_ro;
            r_pready <= (c_WAIT == 4'd0);
          end
        end
        S_ACCESS: begin
          if (!psel) begin
            r_state  <= S_IDLE;
            r_pready <= 1'b0;
          end else if (penable) begin
            if (r_pready) begin
              r_state  <= S_IDLE;
              r_pready <= 1'b0;
              if (r_write && !r_err) begin
                for (int k = 0; k < c_NB; k++) begin
                  if (r_strb[k]) r_regs[r_ridx][8*k +: 8] <= r_wdata[8*k +: 8];
                end
              end
            end else begin
              r_cnt    <= w_cnt_nxt;
              r_pready <= (w_cnt_nxt == c_WAIT);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_apb_regfile_slave                                            |
// | Brief    : Bench for apb_regfile_slave, zero- and three-wait instances.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_apb_regfile_slave;

  logic         clk = 1'b0;
  logic         preset;
  logic         psel0, psel1, penable, pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1, pslverr0, pslverr1;
  logic [511:0] hw_status;
  logic [511:0] regs_q0, regs_q1;

  int nerr = 0;
  int nchk = 0;
  logic [31:0] m [2][16];

  always #5 clk = ~clk;

  apb_regfile_slave #(.WAIT_CYCLES(0), .RO_MASK(16'h0008)) u_dut0 (
    .pclk(clk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .hw_status(hw_status), .regs_q(regs_q0));

  apb_regfile_slave #(.WAIT_CYCLES(3), .RO_MASK(16'h0008)) u_dut1 (
    .pclk(clk), .preset(preset), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .hw_status(hw_status), .regs_q(regs_q1));

  function automatic logic get_rdy(input int d);
    return (d != 0) ? pready1 : pready0;
  endfunction
  function automatic logic get_err(input int d);
    return (d != 0) ? pslverr1 : pslverr0;
  endfunction
  function automatic logic [31:0] get_rd(input int d);
    return (d != 0) ? prdata1 : prdata0;
  endfunction
  function automatic logic [511:0] get_regq(input int d);
    return (d != 0) ? regs_q1 : regs_q0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input int d);
    logic [511:0] q;
    q = get_regq(d);
    for (int i = 0; i < 16; i++) chk($sformatf("regs_q%0d[%0d]", d, i), q[i*32 +: 32], m[d][i]);
  endtask

  // Reference: word index, error rules and byte-lane merge straight from the register map
  task automatic model_xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                            input logic [3:0] st, output logic [31:0] erd, output bit eerr);
    int idx;
    idx  = a / 4;
    eerr = (idx >= 16) || (a % 4 != 0) || (wr && idx == 3);
    erd  = 32'h0;
    if (!eerr && wr) begin
      for (int k = 0; k < 4; k++)
        if (st[k]) m[d][idx] = (m[d][idx] & ~(32'hFF << (8*k))) | (wd & (32'hFF << (8*k)));
    end else if (!eerr) begin
      erd = (idx == 3) ? hw_status[idx*32 +: 32] : m[d][idx];
    end
  endtask

  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit scramble,
                      output logic [31:0] rd, output bit err, output int lat, output bit clean);
    bit done;
    if (d != 0) psel1 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    if (scramble) begin
      paddr = 8'($urandom); pwdata = $urandom; pstrb = 4'($urandom); pwrite = 1'($urandom);
    end
    lat = 1; clean = 1'b1; rd = '0; err = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      lat++;
      if (get_rdy(d)) begin
        rd = get_rd(d); err = get_err(d); done = 1'b1;
      end else begin
        if (get_rd(d) !== 32'h0 || get_err(d) !== 1'b0) clean = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (!done) lat = -1;
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] erd;
    bit          eerr;
    int          elat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd;
    bit err, eerr, clean;
    int lat, d;
    bit wr;
    logic [7:0] a;

    preset = 1'b1; psel0 = 0; psel1 = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; pstrb = 0;
    for (int i = 0; i < 16; i++) hw_status[i*32 +: 32] = 32'hCAFE0000 | i;
    for (int d2 = 0; d2 < 2; d2++) for (int i = 0; i < 16; i++) m[d2][i] = 32'h0;

    // Reset state, then idle hold
    repeat (3) @(posedge clk);
    #1;
    preset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int dd = 0; dd < 2; dd++) begin
        chk("rst_pready", 32'(get_rdy(dd)), 32'h0);
        chk("rst_pslverr", 32'(get_err(dd)), 32'h0);
        chk("rst_prdata", get_rd(dd), 32'h0);
      end
      @(posedge clk); #1;
    end
    chk_regs(0); chk_regs(1);

    tbl[0]  = '{0, 1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0,        0, 2};
    tbl[1]  = '{0, 0, 8'h04, 32'h0,        4'hF, 32'hDEADBEEF, 0, 2};
    tbl[2]  = '{0, 1, 8'h04, 32'h11223344, 4'h5, 32'h0,        0, 2};
    tbl[3]  = '{0, 0, 8'h04, 32'h0,        4'h0, 32'hDE22BE44, 0, 2};
    tbl[4]  = '{0, 1, 8'h40, 32'h55555555, 4'hF, 32'h0,        1, 2};
    tbl[5]  = '{0, 1, 8'h02, 32'h66666666, 4'hF, 32'h0,        1, 2};
    tbl[6]  = '{0, 1, 8'h0C, 32'h77777777, 4'hF, 32'h0,        1, 2};
    tbl[7]  = '{0, 0, 8'h0C, 32'h0,        4'h0, 32'hCAFE0003, 0, 2};
    tbl[8]  = '{0, 0, 8'h04, 32'h0,        4'h0, 32'hDE22BE44, 0, 2};
    tbl[9]  = '{1, 0, 8'h00, 32'h0,        4'h0, 32'h0,        0, 5};
    tbl[10] = '{0, 1, 8'h08, 32'h12345678, 4'h0, 32'h0,        0, 2};

    foreach (tbl[v]) begin
      model_xfer(tbl[v].d, tbl[v].wr, tbl[v].a, tbl[v].wd, tbl[v].st, erd, eerr);
      xfer(tbl[v].d, tbl[v].wr, tbl[v].a, tbl[v].wd, tbl[v].st, 1'b0, rd, err, lat, clean);
      chk($sformatf("tbl%0d_prdata", v), rd, tbl[v].erd);
      chk($sformatf("tbl%0d_pslverr", v), 32'(err), 32'(tbl[v].eerr));
      chk($sformatf("tbl%0d_latency", v), 32'(lat), 32'(tbl[v].elat));
      chk($sformatf("tbl%0d_waitclean", v), 32'(clean), 32'h1);
      chk_regs(tbl[v].d);
    end

    // Three-wait read: pready low for three access cycles, high on the fourth
    psel1 = 1; penable = 0; pwrite = 0; paddr = 8'h00;
    @(posedge clk); #1;
    penable = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wait_pready_c%0d", i), 32'(pready1), (i == 3) ? 32'h1 : 32'h0);
      if (i < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    psel1 = 0; penable = 0;

    // psel dropped mid-wait on a write: abort, no completion, no commit
    psel1 = 1; penable = 0; pwrite = 1; paddr = 8'h14; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    psel1 = 0; penable = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_pready", 32'(pready1), 32'h0);
    end
    chk_regs(1);
    model_xfer(1, 0, 8'h14, 0, 0, erd, eerr);
    xfer(1, 0, 8'h14, 0, 0, 1'b0, rd, err, lat, clean);
    chk("post_abort_latency", 32'(lat), 32'd5);
    chk("post_abort_prdata", rd, erd);

    // penable without a setup phase is ignored in IDLE
    psel0 = 1; penable = 1; pwrite = 1; paddr = 8'h10; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("idle_penable_pready", 32'(pready0), 32'h0);
    end
    psel0 = 0; penable = 0;
    @(posedge clk); #1;
    chk_regs(0);

    // Randomized back-to-back traffic on both instances, bus fields scrambled mid-access
    for (int n = 0; n < 300; n++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = 8'($urandom_range(16, 63) * 4);
        1:       a = 8'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        default: a = 8'($urandom_range(0, 15) * 4);
      endcase
      for (int i = 0; i < 16; i++) hw_status[i*32 +: 32] = $urandom;
      pwdata = $urandom;
      model_xfer(d, wr, a, pwdata, 4'(n), erd, eerr);
      xfer(d, wr, a, pwdata, 4'(n), 1'b1, rd, err, lat, clean);
      chk("rnd_prdata", rd, erd);
      chk("rnd_pslverr", 32'(err), 32'(eerr));
      chk("rnd_latency", 32'(lat), (d != 0) ? 32'd5 : 32'd2);
      chk("rnd_waitclean", 32'(clean), 32'h1);
      chk_regs(d);
    end

    // Reset during the access phase of a write: no commit, IDLE afterwards
    psel0 = 1; penable = 0; pwrite = 1; paddr = 8'h08; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1; preset = 1;
    @(posedge clk); #1;
    preset = 0; psel0 = 0; penable = 0;
    for (int d2 = 0; d2 < 2; d2++) for (int i = 0; i < 16; i++) m[d2][i] = 32'h0;
    chk("rst_mid_pready", 32'(pready0), 32'h0);
    chk("rst_mid_pslverr", 32'(pslverr0), 32'h0);
    chk("rst_mid_reg2", regs_q0[2*32 +: 32], 32'h0);
    chk_regs(0); chk_regs(1);
    xfer(0, 0, 8'h08, 0, 0, 1'b0, rd, err, lat, clean);
    chk("rst_mid_next_latency", 32'(lat), 32'd2);
    chk("rst_mid_next_prdata", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
